// File: rtl/ir_pkg.sv
// rtl/ir_pkg.sv - shared types and constants for the IR packet sequencer
package ir_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_GAP0, S_SELECT, S_GAP1, S_RIGHT, S_GAP2,
    S_LEFT, S_GAP3, S_BACK, S_GAP4, S_FWD, S_GAP5
  } ir_state_e;

  localparam int CMD_RIGHT = 0;
  localparam int CMD_LEFT  = 1;
  localparam int CMD_BACK  = 2;
  localparam int CMD_FWD   = 3;

  typedef struct packed {
    logic [7:0] start_len;
    logic [7:0] select_len;
    logic [7:0] gap_len;
    logic [7:0] assert_len;
    logic [7:0] deassert_len;
  } ir_lens_t;

  // Field lengths in carrier periods, one set per car colour.
  localparam ir_lens_t LENS_RED    = '{8'd191, 8'd47, 8'd25, 8'd47, 8'd22};
  localparam ir_lens_t LENS_BLUE   = '{8'd191, 8'd71, 8'd25, 8'd47, 8'd22};
  localparam ir_lens_t LENS_GREEN  = '{8'd191, 8'd95, 8'd25, 8'd47, 8'd22};
  localparam ir_lens_t LENS_YELLOW = '{8'd191, 8'd119, 8'd25, 8'd47, 8'd22};

  function automatic logic is_burst_state(input ir_state_e s);
    return (s == S_START) || (s == S_SELECT) || (s == S_RIGHT) ||
           (s == S_LEFT) || (s == S_BACK) || (s == S_FWD);
  endfunction

endpackage

// File: rtl/ir_packet_sequencer_if.sv
// rtl/ir_packet_sequencer_if.sv - trigger, carrier and LED signals of the sequencer
interface ir_packet_sequencer_if;
  logic       carrier_clk;
  logic       carrier_pulse;
  logic       send_pulse;
  logic [3:0] command;
  logic       ir_led;
  logic       busy;
  logic       packet_done;

  modport master (
    output carrier_clk, carrier_pulse, send_pulse, command,
    input  ir_led, busy, packet_done
  );

  modport slave (
    input  carrier_clk, carrier_pulse, send_pulse, command,
    output ir_led, busy, packet_done
  );
endinterface

// File: rtl/ir_field_timer.sv
// rtl/ir_field_timer.sv - counts carrier periods within one packet field
module ir_field_timer #(
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   sys_clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   carrier_pulse,
  input  logic [COUNT_WIDTH-1:0] len,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] count
);

  logic last;

  assign last = (count == len - COUNT_WIDTH'(1));
  assign done = carrier_pulse && last;

  always_ff @(posedge sys_clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (carrier_pulse) begin
      count <= last ? '0 : count + COUNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/ir_packet_sequencer.sv
// rtl/ir_packet_sequencer.sv - sequences one modulated IR packet per trigger
module ir_packet_sequencer
  import ir_pkg::*;
#(
  parameter int                     COUNT_WIDTH  = 8,
  parameter logic [COUNT_WIDTH-1:0] START_LEN    = COUNT_WIDTH'(191),
  parameter logic [COUNT_WIDTH-1:0] SELECT_LEN   = COUNT_WIDTH'(47),
  parameter logic [COUNT_WIDTH-1:0] GAP_LEN      = COUNT_WIDTH'(25),
  parameter logic [COUNT_WIDTH-1:0] ASSERT_LEN   = COUNT_WIDTH'(47),
  parameter logic [COUNT_WIDTH-1:0] DEASSERT_LEN = COUNT_WIDTH'(22)
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  ir_packet_sequencer_if.slave  bus
);

  ir_state_e              state, next_state;
  logic [3:0]             cmd_q;
  logic [COUNT_WIDTH-1:0] len;
  logic [COUNT_WIDTH-1:0] count;
  logic                   clear;
  logic                   done;
  logic                   burst;
  logic                   last_field;
  logic                   led_q;
  logic                   done_q;

  ir_field_timer #(.COUNT_WIDTH(COUNT_WIDTH)) u_timer (
    .sys_clk       (sys_clk),
    .reset         (reset),
    .clear         (clear),
    .carrier_pulse (bus.carrier_pulse),
    .len           (len),
    .done          (done),
    .count         (count)
  );

  always_comb begin
    next_state = state;
    len        = GAP_LEN;
    clear      = 1'b0;
    burst      = is_burst_state(state);
    unique case (state)
      S_IDLE: begin
        clear = 1'b1;
        if (bus.send_pulse) next_state = S_START;
      end
      S_START:  len = START_LEN;
      S_SELECT: len = SELECT_LEN;
      S_RIGHT:  len = cmd_q[CMD_RIGHT] ? ASSERT_LEN : DEASSERT_LEN;
      S_LEFT:   len = cmd_q[CMD_LEFT]  ? ASSERT_LEN : DEASSERT_LEN;
      S_BACK:   len = cmd_q[CMD_BACK]  ? ASSERT_LEN : DEASSERT_LEN;
      S_FWD:    len = cmd_q[CMD_FWD]   ? ASSERT_LEN : DEASSERT_LEN;
      default:  len = GAP_LEN;
    endcase
    // Fields are declared in order, so every advance is state+1 except the wrap.
    if (state != S_IDLE && done) begin
      next_state = (state == S_GAP5) ? S_IDLE : ir_state_e'(state + 4'd1);
    end
    last_field = (state == S_GAP5) && done;
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cmd_q  <= '0;
      led_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= next_state;
      led_q  <= burst && bus.carrier_clk;
      done_q <= last_field;
      if (state == S_IDLE && bus.send_pulse) cmd_q <= bus.command;
      lens_nonzero: assert (START_LEN != '0 && SELECT_LEN != '0 && GAP_LEN != '0 &&
                            ASSERT_LEN != '0 && DEASSERT_LEN != '0)
        else $error("ir_packet_sequencer: zero field length parameter");
      count_in_range: assert (state == S_IDLE || count < len)
        else $error("ir_packet_sequencer: field counter beyond length");
    end
  end

  assign bus.ir_led      = led_q;
  assign bus.packet_done = done_q;
  assign bus.busy        = (state != S_IDLE);

endmodule

// File: tb/tb_ir_packet_sequencer.sv
// tb/tb_ir_packet_sequencer.sv - randomized self-checking bench for ir_packet_sequencer
module tb_ir_packet_sequencer;

  localparam int L_START = 4;
  localparam int L_SEL   = 2;
  localparam int L_GAP   = 1;
  localparam int L_ASR   = 3;
  localparam int L_DEA   = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ir_packet_sequencer_if bus ();

  ir_packet_sequencer #(
    .COUNT_WIDTH  (8),
    .START_LEN    (8'd4),
    .SELECT_LEN   (8'd2),
    .GAP_LEN      (8'd1),
    .ASSERT_LEN   (8'd3),
    .DEASSERT_LEN (8'd1)
  ) dut (
    .sys_clk (clk),
    .reset   (rst),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model: a packet is a list of 12 fields, each lasting len carrier pulses.
  bit         m_active = 1'b0;
  int         m_fi = 0;
  int         m_pc = 0;
  int         m_len[12];
  bit         m_burst[12];
  logic [3:0] m_cmd = '0;

  int         per = 4;
  int         ph = 0;
  int         meas = 0;
  int         n_done = 0;
  logic [3:0] cmd_drv = '0;

  function automatic int field_periods(input logic [3:0] c);
    int t;
    t = L_START + L_SEL + 6 * L_GAP;
    for (int i = 0; i < 4; i++) t += c[i] ? L_ASR : L_DEA;
    return t;
  endfunction

  task automatic load_fields(input logic [3:0] c);
    m_len[0] = L_START; m_burst[0] = 1'b1;
    m_len[2] = L_SEL;   m_burst[2] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      m_len[4 + 2 * k]   = c[k] ? L_ASR : L_DEA;
      m_burst[4 + 2 * k] = 1'b1;
    end
    for (int k = 0; k < 6; k++) begin
      m_len[2 * k + 1]   = L_GAP;
      m_burst[2 * k + 1] = 1'b0;
    end
  endtask

  function automatic bit completes_now();
    return m_active && m_fi == 11 && m_pc == m_len[11] - 1 && ph == 0;
  endfunction

  task automatic tick(input bit sp, input bit r);
    bit cc, cp, e_led, e_done;
    cc = (ph < per / 2);
    cp = (ph == 0);
    ph = (ph + 1) % per;
    rst               = r;
    bus.send_pulse    = sp;
    bus.command       = cmd_drv;
    bus.carrier_clk   = cc;
    bus.carrier_pulse = cp;
    if (bus.busy === 1'b1 && cp) meas++;
    e_done = 1'b0;
    if (r) begin
      e_led    = 1'b0;
      m_active = 1'b0;
    end else begin
      e_led = m_active && m_burst[m_fi] && cc;
      if (!m_active) begin
        if (sp) begin
          m_active = 1'b1;
          m_fi     = 0;
          m_pc     = 0;
          m_cmd    = cmd_drv;
          load_fields(cmd_drv);
        end
      end else if (cp) begin
        m_pc++;
        if (m_pc == m_len[m_fi]) begin
          m_pc = 0;
          m_fi++;
          if (m_fi == 12) begin
            m_active = 1'b0;
            e_done   = 1'b1;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    check("ir_led", 32'(bus.ir_led), 32'(e_led));
    check("busy", 32'(bus.busy), 32'(m_active));
    check("packet_done", 32'(bus.packet_done), 32'(e_done));
    if (bus.packet_done === 1'b1) begin
      n_done++;
      check("periods", 32'(meas), 32'(field_periods(m_cmd)));
    end
    if (bus.busy !== 1'b1) meas = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0);
  endtask

  initial begin
    int d0;
    bit found;
    bus.send_pulse = 1'b0; bus.command = '0;
    bus.carrier_clk = 1'b0; bus.carrier_pulse = 1'b0;

    repeat (3) tick(1'b0, 1'b1);
    check("reset_busy", 32'(bus.busy), 32'd0);
    idle(5);

    // Single packet, command 1010: 20 carrier periods.
    cmd_drv = 4'b1010; d0 = n_done;
    tick(1'b1, 1'b0);
    idle(100);
    check("single_done", 32'(n_done - d0), 32'd1);

    // Second trigger 5 periods into the packet must be ignored.
    cmd_drv = 4'b0110; d0 = n_done;
    tick(1'b1, 1'b0);
    idle(20);
    tick(1'b1, 1'b0);
    idle(120);
    check("busy_trigger_done", 32'(n_done - d0), 32'd1);

    // Command flips to 1111 during SELECT; latched 0000 stays in effect.
    cmd_drv = 4'b0000; d0 = n_done;
    tick(1'b1, 1'b0);
    idle(22);
    cmd_drv = 4'b1111;
    idle(80);
    check("cmd_change_done", 32'(n_done - d0), 32'd1);

    // Reset during LEFT, then a full packet.
    cmd_drv = 4'b1010; d0 = n_done; found = 1'b0;
    tick(1'b1, 1'b0);
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_active && m_fi == 6) found = 1'b1;
      else tick(1'b0, 1'b0);
    end
    check("reach_left", 32'(found), 32'd1);
    tick(1'b0, 1'b1);
    check("reset_led", 32'(bus.ir_led), 32'd0);
    idle(100);
    check("reset_no_done", 32'(n_done - d0), 32'd0);
    tick(1'b1, 1'b0);
    idle(100);
    check("after_reset_done", 32'(n_done - d0), 32'd1);

    // Back-to-back: trigger on the completing cycle (ignored) and the next (accepted).
    cmd_drv = 4'b1001; d0 = n_done; found = 1'b0;
    tick(1'b1, 1'b0);
    for (int i = 0; i < 200 && !found; i++) begin
      if (completes_now()) found = 1'b1;
      else tick(1'b0, 1'b0);
    end
    check("b2b_found", 32'(found), 32'd1);
    tick(1'b1, 1'b0);
    check("b2b_ignored", 32'(bus.busy), 32'd0);
    tick(1'b1, 1'b0);
    check("b2b_start", 32'(bus.busy), 32'd1);
    idle(100);
    check("b2b_done", 32'(n_done - d0), 32'd2);

    // Randomized traffic with varying carrier period.
    for (int blk = 0; blk < 6; blk++) begin
      per = $urandom_range(2, 6);
      ph = 0;
      for (int i = 0; i < 500; i++) begin
        cmd_drv = 4'($urandom);
        tick($urandom_range(0, 24) == 0, $urandom_range(0, 599) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
